// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - frame-buffer fetch engine: Avalon pipelined-read master feeding the pixel FIFO
// Issues HDISP*VDISP sequential word reads per frame under credit flow control.
module frame_reader #(
  parameter int          HDISP           = 800,
  parameter int          VDISP           = 480,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic [31:0] address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  input  logic        readdatavalid,
  input  logic        fifo_almost_full,
  output logic [31:0] fifo_wdata,
  output logic        fifo_write,
  output logic        busy,
  output logic        frame_done
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
  localparam logic [3:0]    MAX_C   = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, ABORT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] issued, issued_nx;
  logic [CW-1:0] received, received_nx;
  logic [3:0]    outstanding, outstanding_nx;
  logic          abort_pend, abort_pend_nx;
  logic [31:0]   address_nx;
  logic          read_nx, fifo_write_nx, frame_done_nx;
  logic          accept, rvalid_ok, clear;

  always_comb begin
    accept         = read && !waitrequest;
    // returns with nothing in flight are strays from before a reset
    rvalid_ok      = readdatavalid && (outstanding != 4'd0) && (state != IDLE);
    state_nx       = state;
    abort_pend_nx  = abort_pend;
    clear          = 1'b0;
    frame_done_nx  = 1'b0;
    fifo_write_nx  = rvalid_ok && ((state == READ) || (state == DRAIN));
    issued_nx      = issued + CW'(accept);
    received_nx    = received + CW'(fifo_write_nx);
    outstanding_nx = outstanding + 4'(accept) - 4'(rvalid_ok);
    address_nx     = accept ? address + 32'd4 : address;

    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nx = READ;
          clear    = 1'b1;
        end
      end
      READ: begin
        // an abort during a stalled request waits for the accept
        if (frame_start || abort_pend) begin
          if (read && waitrequest) begin
            abort_pend_nx = 1'b1;
          end else begin
            state_nx      = ABORT;
            abort_pend_nx = 1'b0;
          end
        end else if (issued_nx == TOTAL_C) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_start) begin
          state_nx = ABORT;
        end else if (received_nx == TOTAL_C && outstanding_nx == 4'd0) begin
          state_nx      = IDLE;
          frame_done_nx = 1'b1;
        end
      end
      ABORT: begin
        if (outstanding_nx == 4'd0) begin
          state_nx = READ;
          clear    = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (clear) begin
      issued_nx     = '0;
      received_nx   = '0;
      address_nx    = BASE_ADDR;
      abort_pend_nx = 1'b0;
    end

    if (read && !accept) begin
      read_nx = 1'b1;
    end else begin
      read_nx = (state == READ) && (state_nx == READ) && !abort_pend_nx &&
                (issued_nx < TOTAL_C) && !fifo_almost_full &&
                (outstanding_nx < MAX_C);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issued      <= '0;
      received    <= '0;
      outstanding <= 4'd0;
      abort_pend  <= 1'b0;
      address     <= BASE_ADDR;
      read        <= 1'b0;
      fifo_wdata  <= 32'd0;
      fifo_write  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      issued      <= issued_nx;
      received    <= received_nx;
      outstanding <= outstanding_nx;
      abort_pend  <= abort_pend_nx;
      address     <= address_nx;
      read        <= read_nx;
      fifo_write  <= fifo_write_nx;
      frame_done  <= frame_done_nx;
      if (fifo_write_nx) fifo_wdata <= readdata;
    end
  end

  assign busy = (state != IDLE);

endmodule
